pixel_clamp_pipe: RTL and testbench

Parametrised, pipelined successor to the single-pixel fixed-point clipper. Converts CHANNELS signed fixed-point filter results per beat into unsigned OUT_W-bit pixels with selectable rounding and saturation. Sits between the interpolation MAC array and the output pixel packer. Uses a valid/ready stream handshake and carries a line-end marker alongside the data.

---
 rtl/pixel_pkg.sv | 15 +
 rtl/pixel_round_clamp_ch.sv | 64 ++++++
 rtl/pixel_clamp_pipe.sv | 156 +++++++++++++++
 tb/tb_pixel_clamp_pipe.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared constants for the pixel clamp pipeline: round-mode codes, default
// widths and the clip-statistics counter width.
package pixel_pkg;

  localparam logic [1:0] ROUND_TRUNC     = 2'd0;
  localparam logic [1:0] ROUND_HALF_UP   = 2'd1;
  localparam logic [1:0] ROUND_HALF_EVEN = 2'd2;

  localparam int DEF_IN_W   = 20;
  localparam int DEF_FRAC_W = 7;
  localparam int DEF_OUT_W  = 8;

  localparam int STATS_W = 16;

endpackage

// File: rtl/pixel_round_clamp_ch.sv
// One channel of round + clamp. Purely combinational; the parent's S1
// registers sit between the round half (din_i -> rnd_o) and the clamp half.
module pixel_round_clamp_ch
  import pixel_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int RW     = IN_W + 1 - FRAC_W
) (
  input  logic [IN_W-1:0]  din_i,
  input  logic [1:0]       round_mode_i,
  output logic [RW-1:0]    rnd_o,
  output logic             neg_o,
  input  logic [RW-1:0]    rnd_i,
  input  logic             neg_i,
  output logic [OUT_W-1:0] pix_o,
  output logic             clip_lo_o,
  output logic             clip_hi_o
);

  localparam logic [FRAC_W-1:0] FRAC_HALF = FRAC_W'(1) << (FRAC_W - 1);
  localparam logic [IN_W:0]     HALF      = {{(IN_W + 1 - FRAC_W){1'b0}}, FRAC_HALF};
  localparam logic [IN_W:0]     HALF_M1   = HALF - (IN_W + 1)'(1);

  localparam int CW = ((RW > OUT_W) ? RW : OUT_W) + 1;
  localparam logic [CW-1:0] PIX_MAX = {{(CW - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [IN_W:0] ext;
  logic [IN_W:0] inc;
  logic [IN_W:0] sum;
  logic [CW-1:0] rnd_ext;
  logic          unused_frac;

  // One guard bit above the input so the largest positive value plus the
  // rounding increment cannot wrap into the sign.
  always_comb begin
    ext = {din_i[IN_W-1], din_i};
    inc = '0;
    case (round_mode_i)
      ROUND_TRUNC:     inc = '0;
      ROUND_HALF_EVEN: inc = (din_i[FRAC_W-1:0] == FRAC_HALF && !din_i[FRAC_W]) ? HALF_M1 : HALF;
      default:         inc = HALF;
    endcase
    sum = ext + inc;
  end

  assign rnd_o       = sum[IN_W:FRAC_W];
  assign neg_o       = din_i[IN_W-1];
  assign unused_frac = ^sum[FRAC_W-1:0];

  always_comb begin
    rnd_ext   = CW'(rnd_i);
    clip_lo_o = neg_i;
    clip_hi_o = !neg_i && (rnd_ext > PIX_MAX);
    pix_o     = rnd_ext[OUT_W-1:0];
    if (clip_lo_o) begin
      pix_o = '0;
    end else if (clip_hi_o) begin
      pix_o = '1;
    end
  end

endmodule

// File: rtl/pixel_clamp_pipe.sv
// Two-stage valid/ready pipeline: S1 rounds, S2 clamps to unsigned pixels.
// Optional clip counters are built when PIXEL_CLAMP_STATS_EN is defined.
module pixel_clamp_pipe
  import pixel_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int FRAC_W   = DEF_FRAC_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int CHANNELS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                round_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      out_last
`ifdef PIXEL_CLAMP_STATS_EN
  ,
  input  logic                      stats_clear,
  output logic [STATS_W-1:0]        clip_lo_cnt,
  output logic [STATS_W-1:0]        clip_hi_cnt
`endif
);

  localparam int RW = IN_W + 1 - FRAC_W;

  logic                      s1_valid_q;
  logic                      s1_last_q;
  logic [CHANNELS*RW-1:0]    s1_rnd_q;
  logic [CHANNELS*RW-1:0]    s1_rnd_d;
  logic [CHANNELS-1:0]       s1_neg_q;
  logic [CHANNELS-1:0]       s1_neg_d;

  logic                      s2_valid_q;
  logic                      s2_last_q;
  logic [CHANNELS*OUT_W-1:0] s2_pix_q;
  logic [CHANNELS*OUT_W-1:0] s2_pix_d;
  logic [CHANNELS-1:0]       clip_lo_d;
  logic [CHANNELS-1:0]       clip_hi_d;

  logic                      s1_load;
  logic                      s2_load;

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  assign out_valid = s2_valid_q;
  assign out_data  = s2_pix_q;
  assign out_last  = s2_last_q;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    pixel_round_clamp_ch #(
      .IN_W   (IN_W),
      .FRAC_W (FRAC_W),
      .OUT_W  (OUT_W),
      .RW     (RW)
    ) u_ch (
      .din_i        (in_data[ch*IN_W +: IN_W]),
      .round_mode_i (round_mode),
      .rnd_o        (s1_rnd_d[ch*RW +: RW]),
      .neg_o        (s1_neg_d[ch]),
      .rnd_i        (s1_rnd_q[ch*RW +: RW]),
      .neg_i        (s1_neg_q[ch]),
      .pix_o        (s2_pix_d[ch*OUT_W +: OUT_W]),
      .clip_lo_o    (clip_lo_d[ch]),
      .clip_hi_o    (clip_hi_d[ch])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_rnd_q   <= '0;
      s1_neg_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_pix_q   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_rnd_q  <= s1_rnd_d;
          s1_neg_q  <= s1_neg_d;
          s1_last_q <= in_last;
        end
      end
      if (s2_load) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_pix_q  <= s2_pix_d;
          s2_last_q <= s1_last_q;
        end
      end
    end
  end

`ifdef PIXEL_CLAMP_STATS_EN
  logic [CHANNELS-1:0] s2_lo_q;
  logic [CHANNELS-1:0] s2_hi_q;
  logic [STATS_W-1:0]  lo_cnt_q;
  logic [STATS_W-1:0]  hi_cnt_q;
  logic [STATS_W-1:0]  lo_cnt_d;
  logic [STATS_W-1:0]  hi_cnt_d;
  logic [STATS_W:0]    lo_sum;
  logic [STATS_W:0]    hi_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_lo_q <= '0;
      s2_hi_q <= '0;
    end else if (s2_load && s1_valid_q) begin
      s2_lo_q <= clip_lo_d;
      s2_hi_q <= clip_hi_d;
    end
  end

  // Saturating accumulate of per-beat clip counts; clear wins over increment.
  always_comb begin
    lo_sum   = {1'b0, lo_cnt_q} + (STATS_W + 1)'($countones(s2_lo_q));
    hi_sum   = {1'b0, hi_cnt_q} + (STATS_W + 1)'($countones(s2_hi_q));
    lo_cnt_d = lo_cnt_q;
    hi_cnt_d = hi_cnt_q;
    if (stats_clear) begin
      lo_cnt_d = '0;
      hi_cnt_d = '0;
    end else if (s2_valid_q && out_ready) begin
      lo_cnt_d = lo_sum[STATS_W] ? '1 : lo_sum[STATS_W-1:0];
      hi_cnt_d = hi_sum[STATS_W] ? '1 : hi_sum[STATS_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lo_cnt_q <= '0;
      hi_cnt_q <= '0;
    end else begin
      lo_cnt_q <= lo_cnt_d;
      hi_cnt_q <= hi_cnt_d;
    end
  end

  assign clip_lo_cnt = lo_cnt_q;
  assign clip_hi_cnt = hi_cnt_q;
`else
  logic unused_clip;
  assign unused_clip = ^{clip_lo_d, clip_hi_d};
`endif

endmodule

// File: tb/tb_pixel_clamp_pipe.sv
// Directed bench for pixel_clamp_pipe with default parameters; covers the
// clip counters too when PIXEL_CLAMP_STATS_EN is defined.
module tb_pixel_clamp_pipe;
  import pixel_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  round_mode;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_last;
`ifdef PIXEL_CLAMP_STATS_EN
  logic        stats_clear;
  logic [15:0] clip_lo_cnt;
  logic [15:0] clip_hi_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pixel_clamp_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .round_mode (round_mode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
`ifdef PIXEL_CLAMP_STATS_EN
    ,
    .stats_clear (stats_clear),
    .clip_lo_cnt (clip_lo_cnt),
    .clip_hi_cnt (clip_hi_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [59:0] pk(input logic [19:0] c0, input logic [19:0] c1, input logic [19:0] c2);
    return {c2, c1, c0};
  endfunction

  function automatic logic [23:0] px(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2);
    return {c2, c1, c0};
  endfunction

  task automatic send_one(input logic [1:0] mode, input logic [59:0] data, input logic [23:0] exp, input string tag);
    round_mode = mode;
    in_data    = data;
    in_last    = 1'b0;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({tag, " valid"}, 32'(out_valid), 32'(1));
    chk({tag, " data"}, 32'(out_data), 32'(exp));
  endtask

  initial begin
    int          sent;
    int          recv;
    int          cyc;
    logic [23:0] hold;
    logic        stalled;
    logic        pat [4];

    rst        = 1'b1;
    round_mode = ROUND_TRUNC;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
`ifdef PIXEL_CLAMP_STATS_EN
    stats_clear = 1'b0;
`endif
    repeat (3) step();
    rst = 1'b0;
    chk("reset out_valid", 32'(out_valid), 32'(0));
    chk("reset in_ready", 32'(in_ready), 32'(1));
    chk("reset out_data", 32'(out_data), 32'(0));
    chk("reset out_last", 32'(out_last), 32'(0));

    // Latency: accepted on one edge, visible two stages later.
    round_mode = ROUND_HALF_UP;
    in_data    = pk(20'd64, 20'd32704, 20'd192);
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    chk("latency stage1 out_valid", 32'(out_valid), 32'(0));
    step();
    chk("latency stage2 out_valid", 32'(out_valid), 32'(1));
    chk("half_up data", 32'(out_data), 32'(px(8'd1, 8'd255, 8'd2)));
    step();
    chk("drain out_valid", 32'(out_valid), 32'(0));

    send_one(ROUND_HALF_UP, pk(20'h7FFFF, 20'hFFFFF, 20'h80000), px(8'd255, 8'd0, 8'd0), "extremes");
    send_one(ROUND_HALF_EVEN, pk(20'd192, 20'd320, 20'd64), px(8'd2, 8'd2, 8'd0), "half_even");
    send_one(ROUND_TRUNC, pk(20'd191, 20'd191, 20'd191), px(8'd1, 8'd1, 8'd1), "trunc");
    send_one(ROUND_TRUNC, pk(20'd32767, 20'd32768, 20'd127), px(8'd255, 8'd255, 8'd0), "trunc_edge");
    send_one(ROUND_HALF_UP, pk(20'd320, 20'd64, 20'd0), px(8'd3, 8'd1, 8'd0), "half_up_2p5");
    send_one(2'd3, pk(20'd320, 20'd64, 20'd0), px(8'd3, 8'd1, 8'd0), "mode3");
    step();
    chk("idle out_valid", 32'(out_valid), 32'(0));

    // 16-beat stream with out_ready cycling 1,0,0,1.
    pat        = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent       = 0;
    recv       = 0;
    cyc        = 0;
    stalled    = 1'b0;
    hold       = '0;
    round_mode = ROUND_HALF_UP;
    while (recv < 16 && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 16);
      in_data   = pk(20'(sent * 128), 20'((sent + 100) * 128), 20'((255 - sent) * 128));
      in_last   = (sent == 15);
      #1;
      if (stalled) begin
        chk("stream hold valid", 32'(out_valid), 32'(1));
        chk("stream hold data", 32'(out_data), 32'(hold));
      end
      if (out_valid && out_ready) begin
        chk("stream data", 32'(out_data), 32'(px(8'(recv), 8'(recv + 100), 8'(255 - recv))));
        chk("stream last", 32'(out_last), 32'(recv == 15));
        recv++;
      end
      stalled = out_valid && !out_ready;
      hold    = out_data;
      if (in_valid && in_ready) sent++;
      step();
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("stream sent", 32'(sent), 32'(16));
    chk("stream received", 32'(recv), 32'(16));
    out_ready = 1'b1;
    repeat (3) begin
      step();
      chk("stream no extra", 32'(out_valid), 32'(0));
    end

    // Fill both stages, then reset.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_data   = pk(20'd128, 20'd128, 20'd128);
    step();
    step();
    chk("full out_valid", 32'(out_valid), 32'(1));
    chk("full in_ready", 32'(in_ready), 32'(0));
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    chk("midreset out_valid", 32'(out_valid), 32'(0));
    chk("midreset in_ready", 32'(in_ready), 32'(1));
    chk("midreset out_last", 32'(out_last), 32'(0));
    chk("midreset out_data", 32'(out_data), 32'(0));
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      step();
      chk("post reset no stale", 32'(out_valid), 32'(0));
    end

`ifdef PIXEL_CLAMP_STATS_EN
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    round_mode  = ROUND_HALF_UP;
    in_data     = pk(20'hFFF80, 20'd38400, 20'd128);
    in_valid    = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("stats lo", 32'(clip_lo_cnt), 32'(3));
    chk("stats hi", 32'(clip_hi_cnt), 32'(3));
    stats_clear = 1'b1;
    step();
    stats_clear = 1'b0;
    chk("stats clear lo", 32'(clip_lo_cnt), 32'(0));
    chk("stats clear hi", 32'(clip_hi_cnt), 32'(0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
